// File: rtl/adder32_cla.sv
// adder32_cla: two-level carry-lookahead adder with combinational result and registered copy
//   clk, rst_n     : rising-edge clock, asynchronous active-low clear of sum_q/flags_q
//   op1, op2, cin  : operands and carry in
//   en             : load enable for sum_q/flags_q
//   sum, cout, ovf, zero : combinational result, carry out, signed overflow, zero flag
//   sum_q, flags_q : registered sum and {cout, ovf, zero}
//   ADD32_SUB_EN   : when defined, adds port sub selecting op1 - op2 (cin ignored)
module adder32_cla #(
   parameter int WIDTH = 32,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic             cin,
   input  logic             en,
`ifdef ADD32_SUB_EN
   input  logic             sub,
`endif
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic [WIDTH-1:0] sum_q,
   output logic [2:0]       flags_q
);
   localparam int NG = WIDTH / GROUP;
   logic [WIDTH-1:0] b, g, p, c;
   logic [NG-1:0] gg, gp;
   logic [NG:0] gc;
   logic ci;
   // Flattened sum-of-products carry into position n of a generate/propagate chain
   function automatic logic la(input logic [WIDTH-1:0] gv, pv, input logic c0, input int n);
      logic r, t;
      r = c0;
      for (int j = 0; j < n; j++) r = r & pv[j];
      for (int j = 0; j < n; j++) begin
         t = gv[j];
         for (int m = j + 1; m < n; m++) t = t & pv[m];
         r = r | t;
      end
      return r;
   endfunction
`ifdef ADD32_SUB_EN
   assign b  = sub ? ~op2 : op2;
   assign ci = sub ? 1'b1 : cin;
`else
   assign b  = op2;
   assign ci = cin;
`endif
   assign g = op1 & b;
   assign p = op1 ^ b;
   for (genvar k = 0; k < NG; k++) begin : grp
      assign gg[k] = la(WIDTH'(g[k*GROUP +: GROUP]), WIDTH'(p[k*GROUP +: GROUP]), 1'b0, GROUP);
      assign gp[k] = &p[k*GROUP +: GROUP];
      for (genvar i = 0; i < GROUP; i++) begin : bit_c
         assign c[k*GROUP+i] = la(WIDTH'(g[k*GROUP +: GROUP]), WIDTH'(p[k*GROUP +: GROUP]), gc[k], i);
      end
   end
   for (genvar k = 0; k <= NG; k++) begin : grp_c
      assign gc[k] = la(WIDTH'(gg), WIDTH'(gp), ci, k);
   end
   assign sum  = p ^ c;
   assign cout = gc[NG];
   assign ovf  = (op1[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
   assign zero = ~|sum;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q   <= '0;
         flags_q <= 3'b000;
      end else if (en) begin
         sum_q   <= sum;
         flags_q <= {cout, ovf, zero};
      end
   end
endmodule

// File: tb/tb_adder32_cla.sv
// tb_adder32_cla: directed-vector self-checking bench for adder32_cla
module tb_adder32_cla;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] op1 = '0, op2 = '0;
   logic        cin = 1'b0, en = 1'b0;
`ifdef ADD32_SUB_EN
   logic        sub = 1'b0;
`endif
   logic [31:0] sum, sum_q;
   logic        cout, ovf, zero;
   logic [2:0]  flags_q;
   int n_vec = 0, n_bad = 0;

   adder32_cla dut (
      .clk(clk), .rst_n(rst_n), .op1(op1), .op2(op2), .cin(cin), .en(en),
`ifdef ADD32_SUB_EN
      .sub(sub),
`endif
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .sum_q(sum_q), .flags_q(flags_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, bb, input logic c);
      @(negedge clk);
      op1 = a;
      op2 = bb;
      cin = c;
      #1;
   endtask

   task automatic chk_comb(input string tag, input logic [31:0] s, input logic co, ov, z);
      chk({tag, ".sum"}, sum, s);
      chk({tag, ".cout"}, 32'(cout), 32'(co));
      chk({tag, ".ovf"}, 32'(ovf), 32'(ov));
      chk({tag, ".zero"}, 32'(zero), 32'(z));
   endtask

   task automatic load;
      en = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b0;
   endtask

   initial begin
      logic [32:0] ref_r;
      logic [31:0] ra, rb;
      logic        rc, rovf;
      #2;
      chk("rst.sum_q", sum_q, 32'h0);
      chk("rst.flags_q", 32'(flags_q), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(32'h100, 32'(i), 1'b0);
         chk_comb($sformatf("ofs%0d", i), 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
      end
      drive(32'hFFFF_FFFF, 32'h1, 1'b0);
      chk_comb("wrap", 32'h0, 1'b1, 1'b0, 1'b1);
      load();
      chk("wrap.sum_q", sum_q, 32'h0);
      chk("wrap.flags_q", 32'(flags_q), 32'h5);
      drive(32'h7FFF_FFFF, 32'h1, 1'b0);
      chk_comb("ovf_pos", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      drive(32'h8000_0000, 32'h8000_0000, 1'b0);
      chk_comb("ovf_neg", 32'h0, 1'b1, 1'b1, 1'b1);
      load();
      chk("ovf_neg.flags_q", 32'(flags_q), 32'h7);
      drive(32'h0FFF_FFFF, 32'h1, 1'b0);
      chk_comb("chain28", 32'h1000_0000, 1'b0, 1'b0, 1'b0);
      drive(32'h00FF_FFFF, 32'h1, 1'b0);
      chk_comb("chain24", 32'h0100_0000, 1'b0, 1'b0, 1'b0);
      drive(32'hFFFF_FFFF, 32'h0, 1'b1);
      chk_comb("cin_wrap", 32'h0, 1'b1, 1'b0, 1'b1);
      drive(32'h0000_000F, 32'h0000_0010, 1'b1);
      chk_comb("cin_grp", 32'h0000_0020, 1'b0, 1'b0, 1'b0);
      drive(32'h1234_5678, 32'h1, 1'b0);
      load();
      chk("hold.load", sum_q, 32'h1234_5679);
      chk("hold.flags", 32'(flags_q), 32'h0);
      drive(32'hAAAA_0000, 32'h0000_5555, 1'b0);
      chk("hold.sum", sum, 32'hAAAA_5555);
      @(posedge clk);
      #1;
      chk("hold.sum_q", sum_q, 32'h1234_5679);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.sum_q", sum_q, 32'h0);
      chk("arst.flags_q", 32'(flags_q), 32'h0);
      chk("arst.sum", sum, 32'hAAAA_5555);
      drive(32'hFFFF_FFFF, 32'h1, 1'b0);
      load();
      chk("arst_pri.sum_q", sum_q, 32'h0);
      chk("arst_pri.flags_q", 32'(flags_q), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(32'hAAAA_0000, 32'h0000_5555, 1'b0);
      load();
      chk("post_rst.sum_q", sum_q, 32'hAAAA_5555);
      for (int i = 0; i < 200; i++) begin
         ra = $urandom;
         rb = (i % 4 == 0) ? ~ra : $urandom;
         rc = 1'($urandom_range(1));
         drive(ra, rb, rc);
         ref_r = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
         rovf = (ra[31] == rb[31]) && (ref_r[31] != ra[31]);
         chk_comb($sformatf("rnd%0d", i), ref_r[31:0], ref_r[32], rovf, ref_r[31:0] == 32'h0);
      end
`ifdef ADD32_SUB_EN
      sub = 1'b1;
      drive(32'd5, 32'd7, 1'b0);
      chk_comb("sub5_7", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      drive(32'd7, 32'd5, 1'b1);
      chk_comb("sub7_5", 32'h2, 1'b1, 1'b0, 1'b0);
      drive(32'h8000_0000, 32'h1, 1'b0);
      chk_comb("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
      drive(32'h1234, 32'h1234, 1'b0);
      chk_comb("sub_eq", 32'h0, 1'b1, 1'b0, 1'b1);
      sub = 1'b0;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #90000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
